// File: rtl/xbar_pipe_np.sv
// Registered NUM_PORT x NUM_PORT crossbar with per-output skid-free holding registers,
// atomic multicast and sticky grant-conflict flag. Define XBAR_STATS_EN for per-output flit counters.
module xbar_pipe_np #(
    parameter int NUM_PORT   = 5,
    parameter int WIDTH_XBAR = 64,
    parameter int CNT_W      = 16
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_PORT*NUM_PORT-1:0]   allocVector,
    input  logic [NUM_PORT*WIDTH_XBAR-1:0] din,
    input  logic [NUM_PORT-1:0]            din_valid,
    output logic [NUM_PORT-1:0]            din_ready,
    output logic [NUM_PORT*WIDTH_XBAR-1:0] dout,
    output logic [NUM_PORT-1:0]            dout_valid,
    input  logic [NUM_PORT-1:0]            dout_ready,
    input  logic                           clr_err,
    output logic                           conflict_err,
    output logic [NUM_PORT*CNT_W-1:0]      flit_cnt
);

    logic [NUM_PORT-1:0]   win_hot [NUM_PORT];
    logic [NUM_PORT-1:0]   col_seen;
    logic [NUM_PORT-1:0]   col_multi;
    logic [NUM_PORT-1:0]   granted;
    logic [NUM_PORT-1:0]   blocked;
    logic [NUM_PORT-1:0]   free;
    logic [NUM_PORT-1:0]   fire;
    logic [NUM_PORT-1:0]   load;
    logic [WIDTH_XBAR-1:0] ld_data [NUM_PORT];
    logic                  any_conflict;

    assign free = ~dout_valid | dout_ready;

    // Per output column: one-hot of the lowest-index granted input, plus multi-grant detect.
    always_comb begin
        for (int o = 0; o < NUM_PORT; o++) begin
            win_hot[o]   = '0;
            col_seen[o]  = 1'b0;
            col_multi[o] = 1'b0;
            for (int i = 0; i < NUM_PORT; i++) begin
                if (allocVector[o*NUM_PORT+i]) begin
                    if (col_seen[o]) begin
                        col_multi[o] = 1'b1;
                    end else begin
                        win_hot[o][i] = 1'b1;
                        col_seen[o]   = 1'b1;
                    end
                end
            end
        end
    end

    assign any_conflict = |col_multi;

    // An input is ready only if every output it asks for is both won and free,
    // which makes multicast all-or-nothing.
    always_comb begin
        granted = '0;
        blocked = '0;
        for (int i = 0; i < NUM_PORT; i++) begin
            for (int o = 0; o < NUM_PORT; o++) begin
                if (allocVector[o*NUM_PORT+i]) begin
                    granted[i] = 1'b1;
                    if (!(win_hot[o][i] && free[o])) begin
                        blocked[i] = 1'b1;
                    end
                end
            end
        end
    end

    assign din_ready = granted & ~blocked;
    assign fire      = din_valid & din_ready;

    always_comb begin
        for (int o = 0; o < NUM_PORT; o++) begin
            load[o]    = |(win_hot[o] & fire);
            ld_data[o] = '0;
            for (int i = 0; i < NUM_PORT; i++) begin
                if (win_hot[o][i]) begin
                    ld_data[o] = din[i*WIDTH_XBAR +: WIDTH_XBAR];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout       <= '0;
            dout_valid <= '0;
        end else begin
            for (int o = 0; o < NUM_PORT; o++) begin
                if (load[o]) begin
                    dout[o*WIDTH_XBAR +: WIDTH_XBAR] <= ld_data[o];
                    dout_valid[o]                    <= 1'b1;
                end else if (dout_ready[o]) begin
                    dout_valid[o] <= 1'b0;
                end
            end
        end
    end

    // Set has priority over clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            conflict_err <= 1'b0;
        end else begin
            conflict_err <= any_conflict | (conflict_err & ~clr_err);
        end
    end

`ifdef XBAR_STATS_EN
    logic [CNT_W-1:0] cnt [NUM_PORT];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int o = 0; o < NUM_PORT; o++) begin
                cnt[o] <= '0;
            end
        end else begin
            for (int o = 0; o < NUM_PORT; o++) begin
                if (dout_valid[o] && dout_ready[o] && (cnt[o] != {CNT_W{1'b1}})) begin
                    cnt[o] <= cnt[o] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        flit_cnt = '0;
        for (int o = 0; o < NUM_PORT; o++) begin
            flit_cnt[o*CNT_W +: CNT_W] = cnt[o];
        end
    end
`else
    assign flit_cnt = '0;
`endif

endmodule

// File: tb/tb_xbar_pipe_np.sv
// Directed bench for xbar_pipe_np: single-cycle vector table plus stall, conflict,
// reset, streaming and counter-saturation sequences.
module tb_xbar_pipe_np;
    localparam int N  = 5;
    localparam int W  = 64;
    localparam int CW = 4;
`ifdef XBAR_STATS_EN
    localparam int STATS = 1;
`else
    localparam int STATS = 0;
`endif

    logic             clk = 1'b0;
    logic             rst_n;
    logic [N*N-1:0]   alloc;
    logic [N*W-1:0]   din;
    logic [N-1:0]     din_valid;
    logic [N-1:0]     din_ready;
    logic [N*W-1:0]   dout;
    logic [N-1:0]     dout_valid;
    logic [N-1:0]     dout_ready;
    logic             clr_err;
    logic             conflict_err;
    logic [N*CW-1:0]  flit_cnt;

    int n_chk  = 0;
    int n_fail = 0;

    xbar_pipe_np #(.NUM_PORT(N), .WIDTH_XBAR(W), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .allocVector(alloc), .din(din), .din_valid(din_valid),
        .din_ready(din_ready), .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
        .clr_err(clr_err), .conflict_err(conflict_err), .flit_cnt(flit_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [N*N-1:0] alloc;
        logic [N-1:0]   valid;
        logic [39:0]    data;
        logic [N-1:0]   exp_rdy;
        logic [N-1:0]   exp_dv;
        logic [39:0]    exp_dout;
        logic           exp_err;
    } vec_t;

    vec_t vecs [9];

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_data(input logic [39:0] bytes);
        for (int i = 0; i < N; i++) din[i*W +: W] = {56'h0, bytes[i*8 +: 8]};
    endtask

    function automatic logic [W-1:0] dslice(input int o);
        return dout[o*W +: W];
    endfunction

    function automatic logic [W-1:0] cslice(input int o);
        return W'(flit_cnt[o*CW +: CW]);
    endfunction

    initial begin
        //            alloc          valid     data            rdy       dv        exp_dout        err
        vecs[0] = '{25'h040_0000, 5'b00100, 40'h00_00_A5_00_00, 5'b00100, 5'b10000, 40'hA5_00_00_00_00, 1'b0};
        vecs[1] = '{25'h000_0000, 5'b11111, 40'h01_02_03_04_05, 5'b00000, 5'b00000, 40'h0,              1'b0};
        vecs[2] = '{25'h000_8020, 5'b00001, 40'h00_00_00_00_11, 5'b00001, 5'b01010, 40'h00_11_00_11_00, 1'b0};
        vecs[3] = '{25'h000_000A, 5'b01010, 40'h00_33_00_22_00, 5'b00010, 5'b00001, 40'h00_00_00_00_22, 1'b1};
        vecs[4] = '{25'h104_1041, 5'b11111, 40'h14_13_12_11_10, 5'b11111, 5'b11111, 40'h14_13_12_11_10, 1'b0};
        vecs[5] = '{25'h040_0000, 5'b00000, 40'h00_00_5A_00_00, 5'b00100, 5'b00000, 40'h0,              1'b0};
        vecs[6] = '{25'h001_0C20, 5'b00011, 40'h00_00_00_C1_C0, 5'b00001, 5'b00110, 40'h00_00_C0_C0_00, 1'b1};
        vecs[7] = '{25'h000_000A, 5'b00000, 40'h0,              5'b00010, 5'b00000, 40'h0,              1'b1};
        vecs[8] = '{25'h010_0110, 5'b11001, 40'hD4_D3_00_00_D0, 5'b11001, 5'b10011, 40'hD0_00_00_D3_D4, 1'b0};

        rst_n = 1'b0; alloc = '0; din = '0; din_valid = '0; dout_ready = '1; clr_err = 1'b0;
        #3;
        chk("rst_dout_valid", W'(dout_valid), '0);
        chk("rst_dout", dout[W-1:0] | dout[4*W +: W], '0);
        chk("rst_err", W'(conflict_err), '0);
        chk("rst_cnt", W'(flit_cnt), '0);
        chk("rst_din_ready_nogrant", W'(din_ready), '0);
        #9 rst_n = 1'b1;
        tick();

        for (int v = 0; v < 9; v++) begin
            alloc = vecs[v].alloc; din_valid = vecs[v].valid; dout_ready = '1; clr_err = 1'b1;
            set_data(vecs[v].data);
            #1;
            chk($sformatf("vec%0d_din_ready", v), W'(din_ready), W'(vecs[v].exp_rdy));
            tick();
            chk($sformatf("vec%0d_dout_valid", v), W'(dout_valid), W'(vecs[v].exp_dv));
            for (int o = 0; o < N; o++)
                if (vecs[v].exp_dv[o])
                    chk($sformatf("vec%0d_dout%0d", v, o), dslice(o), W'(vecs[v].exp_dout[o*8 +: 8]));
            chk($sformatf("vec%0d_conflict_err", v), W'(conflict_err), W'(vecs[v].exp_err));
        end
        clr_err = 1'b0;

        // multicast held off by a stalled output
        alloc = 25'h000_8000; din_valid = 5'b00001; set_data(40'h77); dout_ready = '1;
        tick();
        chk("mc_pre_dv", W'(dout_valid), W'(5'b01000));
        chk("mc_pre_dout3", dslice(3), 64'h77);
        alloc = 25'h000_8020; set_data(40'h11); dout_ready = 5'b10111;
        #1;
        chk("mc_stall_din_ready", W'(din_ready), '0);
        tick();
        chk("mc_stall_dv", W'(dout_valid), W'(5'b01000));
        chk("mc_stall_dout3", dslice(3), 64'h77);
        dout_ready = '1;
        #1;
        chk("mc_go_din_ready", W'(din_ready), W'(5'b00001));
        tick();
        chk("mc_go_dv", W'(dout_valid), W'(5'b01010));
        chk("mc_go_dout1", dslice(1), 64'h11);
        chk("mc_go_dout3", dslice(3), 64'h11);
        din_valid = '0;
        tick();
        chk("mc_drain_dv", W'(dout_valid), '0);

        // conflict, stickiness, clear
        alloc = 25'h000_000A; din_valid = 5'b01010; set_data(40'h00_33_00_22_00); clr_err = 1'b0;
        #1;
        chk("cf_din_ready", W'(din_ready), W'(5'b00010));
        tick();
        chk("cf_err_set", W'(conflict_err), 64'h1);
        chk("cf_dout0", dslice(0), 64'h22);
        alloc = '0; din_valid = '0;
        tick();
        chk("cf_err_sticky", W'(conflict_err), 64'h1);
        clr_err = 1'b1;
        tick();
        chk("cf_err_clr", W'(conflict_err), '0);
        clr_err = 1'b0;

        // reset while an output is stalled
        alloc = 25'h1; din_valid = 5'b00001; set_data(40'h33); dout_ready = '0;
        tick();
        chk("rs_load_dv", W'(dout_valid), W'(5'b00001));
        din_valid = '0;
        tick();
        chk("rs_stall_dv", W'(dout_valid), W'(5'b00001));
        chk("rs_stall_dout0", dslice(0), 64'h33);
        #2 rst_n = 1'b0;
        #1;
        chk("rs_async_dv", W'(dout_valid), '0);
        chk("rs_async_dout0", dslice(0), '0);
        chk("rs_async_cnt", W'(flit_cnt), '0);
        chk("rs_din_ready", W'(din_ready), W'(5'b00001));
        #3 rst_n = 1'b1;
        din_valid = 5'b00001; set_data(40'h44); dout_ready = '1;
        tick();
        chk("rs_after_dv", W'(dout_valid), W'(5'b00001));
        chk("rs_after_dout0", dslice(0), 64'h44);
        din_valid = '0;
        tick();

        // streaming in4 -> out2
        #1 rst_n = 1'b0;
        #2 rst_n = 1'b1;
        alloc = 25'h000_4000; dout_ready = '1;
        for (int k = 0; k < 10; k++) begin
            din_valid = 5'b10000; din = '0; din[4*W +: W] = W'(k);
            tick();
            chk($sformatf("st_dv_%0d", k), W'(dout_valid[2]), 64'h1);
            chk($sformatf("st_dout_%0d", k), dslice(2), W'(k));
        end
        din_valid = '0;
        tick();
        chk("st_end_dv", W'(dout_valid[2]), '0);
        chk("st_cnt2", cslice(2), W'(STATS ? 10 : 0));

        // 20 drains on out1 saturate a 4-bit counter
        #1 rst_n = 1'b0;
        #2 rst_n = 1'b1;
        alloc = 25'h000_0200;
        for (int k = 0; k < 20; k++) begin
            din_valid = 5'b10000; din = '0; din[4*W +: W] = W'(k + 100);
            tick();
        end
        chk("sat_last_dout1", dslice(1), W'(119));
        din_valid = '0;
        tick();
        chk("sat_cnt1", cslice(1), W'(STATS ? 15 : 0));
        chk("sat_cnt2", cslice(2), '0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
